// File: rtl/ro_entropy_bank.sv
// rtl/ro_entropy_bank.sv - multi-channel ring-oscillator entropy source with
// von Neumann debiasing, repetition-count health test and word packing.
`timescale 1ns/1ps
module ro_entropy_bank #(
    parameter int NUM_RO     = 8,
    parameter int STAGES     = 3,
    parameter int WORD_W     = 32,
    parameter int WARMUP_CYC = 256,
    parameter int DEBIAS     = 1,
    parameter int REP_LIMIT  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              test_mode,
    input  logic [NUM_RO-1:0] test_bits,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              health_fail,
    output logic              busy
);
    localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int CNT_W  = $clog2(WORD_W + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD, S_FAIL} state_e;

    state_e              state_q, state_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic                prev_q, prev_d;
    logic                phase_q, phase_d;
    logic                a_q, a_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                hf_q, hf_d;
    logic                busy_q, busy_d;
    logic [NUM_RO-1:0]   sync1_q, sync2_q, ring_out;
    logic                raw_q;
    logic                ring_en, active, emit, emit_bit;

    assign ring_en = en & ~test_mode & busy_q;

    // Each ring's first node is forced low while disabled so the loop settles.
    for (genvar g = 0; g < NUM_RO; g++) begin : g_ring
        (* keep = "true", dont_touch = "true" *) logic [STAGES-1:0] node;
        assign node[0] = ring_en & ~node[STAGES-1];
        for (genvar s = 1; s < STAGES; s++) begin : g_stage
            assign node[s] = ~node[s-1];
        end
        assign ring_out[g] = node[STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            raw_q   <= 1'b0;
        end else begin
            sync1_q <= test_mode ? test_bits : ring_out;
            sync2_q <= sync1_q;
            raw_q   <= ^sync2_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        prev_d   = prev_q;
        phase_d  = phase_q;
        a_d      = a_q;
        shreg_d  = shreg_q;
        data_d   = data_q;
        valid_d  = valid_q;
        emit     = 1'b0;
        emit_bit = raw_q;
        active   = (state_q == S_WARMUP) || (state_q == S_COLLECT) || (state_q == S_HOLD);

        // rep_q == 0 marks "no previous bit yet" right after leaving IDLE.
        if (active) begin
            prev_d = raw_q;
            rep_d  = (rep_q != '0 && raw_q == prev_q) ? rep_q + 1'b1 : REP_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                warm_d  = '0;
                cnt_d   = '0;
                rep_d   = '0;
                phase_d = 1'b0;
                valid_d = 1'b0;
                if (en) state_d = S_WARMUP;
            end
            S_WARMUP: begin
                if (warm_q == WARM_W'(WARMUP_CYC - 1)) state_d = S_COLLECT;
                else warm_d = warm_q + 1'b1;
            end
            S_COLLECT: begin
                if (DEBIAS == 0) begin
                    emit = 1'b1;
                end else begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        a_d = raw_q;
                    end else if (a_q != raw_q) begin
                        emit     = 1'b1;
                        emit_bit = a_q;
                    end
                end
                if (emit) begin
                    shreg_d = {shreg_q[WORD_W-2:0], emit_bit};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(WORD_W)) begin
                        data_d  = shreg_d;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (rnd_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_COLLECT;
                end
            end
            default: valid_d = 1'b0;
        endcase

        if (active && rep_d == REP_W'(REP_LIMIT)) begin
            state_d = S_FAIL;
            valid_d = 1'b0;
        end
        if (!en) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end

        hf_d   = (state_d == S_FAIL);
        busy_d = (state_d == S_WARMUP) || (state_d == S_COLLECT) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            warm_q  <= '0;
            cnt_q   <= '0;
            rep_q   <= '0;
            prev_q  <= 1'b0;
            phase_q <= 1'b0;
            a_q     <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            hf_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            prev_q  <= prev_d;
            phase_q <= phase_d;
            a_q     <= a_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            hf_q    <= hf_d;
            busy_q  <= busy_d;
        end
    end

    assign rnd_data    = data_q;
    assign rnd_valid   = valid_q;
    assign health_fail = hf_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_ro_entropy_bank.sv
// tb/tb_ro_entropy_bank.sv - scoreboard bench for ro_entropy_bank (raw and
// debiased instances driven from a shared test_bits stream).
`timescale 1ns/1ps
module tb_ro_entropy_bank;
    localparam int P_ALT = 0, P_PAIR = 1, P_STUCK = 2, P_RAND = 3;

    typedef struct {
        logic [7:0] data;
        int         end_edge;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       test_mode;
    logic [3:0] test_bits;
    logic [1:0] en_v, rdy_v, val_v, hf_v, busy_v;
    logic [7:0] data0, data1;

    exp_t       q0[$], q1[$];
    int         cyc = 0, n_checks = 0, n_errors = 0;
    int         pat_mode = P_RAND, pair_base = 0;
    logic [3:0] rnd_pat[2048];
    logic [3:0] pair_pat[8];
    logic [1:0] pval = 2'b00;
    logic [7:0] held[2];
    int         words_seen[2];
    int         last_hs[2];

    always #5 clk = ~clk;

    ro_entropy_bank #(.NUM_RO(4), .STAGES(3), .WORD_W(8), .WARMUP_CYC(16), .DEBIAS(0), .REP_LIMIT(8)) u_raw (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .test_mode(test_mode), .test_bits(test_bits),
        .rnd_data(data0), .rnd_valid(val_v[0]), .rnd_ready(rdy_v[0]), .health_fail(hf_v[0]), .busy(busy_v[0]));

    ro_entropy_bank #(.NUM_RO(4), .STAGES(3), .WORD_W(8), .WARMUP_CYC(16), .DEBIAS(1), .REP_LIMIT(8)) u_deb (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .test_mode(test_mode), .test_bits(test_bits),
        .rnd_data(data1), .rnd_valid(val_v[1]), .rnd_ready(rdy_v[1]), .health_fail(hf_v[1]), .busy(busy_v[1]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // test_bits applied before clock edge k
    function automatic logic [3:0] gen(input int k);
        case (pat_mode)
            P_ALT:   return (k % 2 != 0) ? 4'b0001 : 4'b0000;
            P_PAIR:  return pair_pat[(k - pair_base) & 7];
            P_STUCK: return 4'b0000;
            default: return rnd_pat[k & 2047];
        endcase
    endfunction

    // raw bit consumed by the collector at edge k
    function automatic logic raw_at(input int k);
        return ^gen(k - 3);
    endfunction

    task automatic predict(input int i, input int s);
        logic [7:0] w = 8'h00;
        int   n = 0;
        int   k = s;
        logic a = 1'b0, ph = 1'b0, r;
        exp_t e;
        while (n < 8 && k < s + 400) begin
            r = raw_at(k);
            if (i == 0) begin
                w = {w[6:0], r};
                n++;
            end else if (!ph) begin
                a  = r;
                ph = 1'b1;
            end else begin
                ph = 1'b0;
                if (a != r) begin
                    w = {w[6:0], a};
                    n++;
                end
            end
            k++;
        end
        e.data     = w;
        e.end_edge = k - 1;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic monitor(input int i);
        logic [7:0] d  = (i == 0) ? data0 : data1;
        logic       hs = pval[i] & rdy_v[i] & en_v[i];
        int         qs = (i == 0) ? q0.size() : q1.size();
        exp_t       e;
        if (val_v[i] && !pval[i]) begin
            words_seen[i]++;
            check_eq("word_expected", 32'(qs > 0), 1);
            if (qs > 0) begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check_eq("word_data", 32'(d), 32'(e.data));
                check_eq("word_edge", cyc, e.end_edge);
            end
            held[i] = d;
        end else if (val_v[i] && pval[i]) begin
            check_eq("hold_data", 32'(d), 32'(held[i]));
        end
        if (hs) begin
            last_hs[i] = cyc;
            check_eq("valid_drop", 32'(val_v[i]), 0);
            if (i == 0) predict(0, cyc + 1);
        end
        pval[i] = val_v[i];
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        monitor(0);
        monitor(1);
        test_bits = gen(cyc + 1);
    endtask

    task automatic wait_word(input int i, input int budget, input string tag);
        int start = words_seen[i];
        int t = 0;
        while (words_seen[i] == start && t < budget) begin
            tick();
            t++;
        end
        check_eq(tag, 32'(words_seen[i] != start), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, e0;
        logic saw_valid, last;
        int run;
        logic [3:0] v;

        pair_pat = '{4'b0000, 4'b0111, 4'b1000, 4'b1101, 4'b0100, 4'b1100, 4'b1111, 4'b0101};
        run  = 0;
        last = 1'b0;
        for (int k = 0; k < 2048; k++) begin
            v = 4'($urandom_range(0, 15));
            if (k > 0 && (^v) == last && run >= 3) v = v ^ 4'b0001;
            if (k > 0 && (^v) == last) run++;
            else run = 1;
            last = ^v;
            rnd_pat[k] = v;
        end
        words_seen = '{0, 0};
        last_hs    = '{0, 0};
        rst_n     = 1'b0;
        en_v      = 2'b00;
        rdy_v     = 2'b00;
        test_mode = 1'b1;
        test_bits = gen(1);

        repeat (3) tick();
        check_eq("rst_valid", 32'(val_v), 0);
        check_eq("rst_data0", 32'(data0), 0);
        check_eq("rst_data1", 32'(data1), 0);
        check_eq("rst_health", 32'(hf_v), 0);
        check_eq("rst_busy", 32'(busy_v), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // alternating raw stream, ready always high
        pat_mode = P_ALT;
        rdy_v[0] = 1'b1;
        repeat (4) tick();
        en_v[0] = 1'b1;
        predict(0, cyc + 18);
        tick();
        check_eq("t1_busy", 32'(busy_v[0]), 1);
        wait_word(0, 60, "t1_word1");
        check_eq("t1_alt_pattern", 32'(data0 == 8'hAA || data0 == 8'h55), 1);
        wait_word(0, 40, "t1_word2");
        check_eq("t1_health", 32'(hf_v[0]), 0);
        en_v[0] = 1'b0;
        q0.delete();
        tick();
        check_eq("t1_off_valid", 32'(val_v[0]), 0);
        check_eq("t1_off_busy", 32'(busy_v[0]), 0);

        // backpressure on a pseudo-random stream
        pat_mode = P_RAND;
        rdy_v[0] = 1'b0;
        repeat (4) tick();
        en_v[0] = 1'b1;
        predict(0, cyc + 18);
        wait_word(0, 60, "t2_word1");
        repeat (20) begin
            tick();
            check_eq("t2_bp_valid", 32'(val_v[0]), 1);
        end
        rdy_v[0] = 1'b1;
        tick();
        rdy_v[0] = 1'b0;
        wait_word(0, 60, "t2_word2");
        check_eq("t2_gap_ge8", 32'(cyc - last_hs[0] >= 8), 1);

        // abort with 5 bits collected, then re-enable
        rdy_v[0] = 1'b1;
        tick();
        rdy_v[0] = 1'b0;
        repeat (5) tick();
        en_v[0] = 1'b0;
        q0.delete();
        tick();
        check_eq("t5_abort_valid", 32'(val_v[0]), 0);
        check_eq("t5_abort_busy", 32'(busy_v[0]), 0);
        repeat (2) tick();
        en_v[0] = 1'b1;
        predict(0, cyc + 18);
        tick();
        check_eq("t5_rebusy", 32'(busy_v[0]), 1);
        wait_word(0, 60, "t5_word");

        // asynchronous reset while holding a word
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(val_v[0]), 0);
        check_eq("t6_rst_data", 32'(data0), 0);
        check_eq("t6_rst_busy", 32'(busy_v[0]), 0);
        check_eq("t6_rst_health", 32'(hf_v[0]), 0);
        #1 rst_n = 1'b1;
        q0.delete();
        pval[0] = 1'b0;
        predict(0, cyc + 18);
        wait_word(0, 60, "t6_word");
        en_v[0] = 1'b0;
        q0.delete();
        tick();

        // von Neumann debiasing on aligned pairs
        pat_mode  = P_PAIR;
        pair_base = cyc + 5 + 17 - 3;
        repeat (4) tick();
        en_v[1] = 1'b1;
        predict(1, cyc + 18);
        wait_word(1, 100, "t3_word");
        check_eq("t3_vn_55", 32'(data1), 'h55);
        check_eq("t3_health", 32'(hf_v[1]), 0);
        en_v[1] = 1'b0;
        q1.delete();
        tick();
        check_eq("t3_off_valid", 32'(val_v[1]), 0);

        // stuck source trips the repetition test during warmup
        pat_mode = P_STUCK;
        repeat (5) tick();
        en_v[0]   = 1'b1;
        e0        = cyc + 1;
        saw_valid = 1'b0;
        lat       = -1;
        for (int t = 0; t < 40 && lat < 0; t++) begin
            tick();
            saw_valid = saw_valid | val_v[0];
            if (hf_v[0]) lat = cyc - e0;
        end
        check_eq("t4_hf_seen", 32'(hf_v[0]), 1);
        check_eq("t4_hf_latency", 32'(lat == 8 || lat == 9), 1);
        check_eq("t4_fail_busy", 32'(busy_v[0]), 0);
        repeat (5) begin
            tick();
            saw_valid = saw_valid | val_v[0];
        end
        check_eq("t4_hf_sticky", 32'(hf_v[0]), 1);
        check_eq("t4_no_valid", 32'(saw_valid), 0);
        en_v[0] = 1'b0;
        tick();
        check_eq("t4_hf_clear", 32'(hf_v[0]), 0);
        check_eq("t4_idle_busy", 32'(busy_v[0]), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
